signal_diffuser: RTL
====================

# signal_diffuser

Once per game tick, raster-sweeps the pheromone grid held in `environment`, forms a 3×3 neighbourhood of every cell from two row line buffers, and writes back a diffused and decayed signal value. It sits beside the ant write path: it issues reads on the environment lookup port and write requests on the environment write port. It runs between game ticks, when `simState_controller` is not updating ants.

## Interface
Parameters:
- `GRID_W`, 160: cells per row (640/4).
- `GRID_H`, 120: rows (480/4).
- `X_bits`, 8: x-coordinate width.
- `Y_bits`, 7: y-coordinate width.
- `SIGNAL_bits`, 8: signal value width.
- `SIGNAL_DECAY`, 1: value subtracted per sweep (saturating).

Ports:
- `newLocClock` in 1: sole clock.
- `RESET_SIM` in 1: reset, synchronous, active-high.
- `start` in 1: one-cycle request to begin a sweep.
- `busy` out 1: sweep in progress.
- `done` out 1: one-cycle pulse when the sweep completes.
- `rd_x` / `rd_y` out `X_bits` / `Y_bits`: lookup address.
- `rd_signal` in `SIGNAL_bits`: lookup data, registered one cycle after the address.
- `wr_flag` out 1: write request valid.
- `wr_ready` in 1: write accepted when `wr_flag && wr_ready`.
- `wr_x` / `wr_y` out `X_bits` / `Y_bits`: write address.
- `wr_signal` out `SIGNAL_bits`: new value.

## Operation
- FSM states: IDLE, SWEEP, DRAIN, DONE.
  - IDLE → SWEEP on `start`.
  - SWEEP → DRAIN after the last scan position is issued.
  - DRAIN → DONE when the pipeline is empty.
  - DONE → IDLE unconditionally.
  - `start` is ignored outside IDLE.
- Scan position (sx, sy):
  - sx runs 0..GRID_W and sy runs 0..GRID_H, row-major; this is (GRID_W+1)×(GRID_H+1) positions, one per cycle.
  - Positions with sx==GRID_W or sy==GRID_H are phantom: `rd_x`/`rd_y` hold their last value and a zero is injected in place of read data.
- Window and line buffers:
  - Each arriving value shifts into a 3-column window; rows y-1 and y-2 come from two GRID_W-deep line buffers.
  - Window center is (cx, cy) = (sx-1, sy-1).
  - A write is emitted only when sx≥1 and sy≥1.
- Out-of-grid neighbours (cx-1<0, cy-1<0) are masked to 0 by coordinate, not by buffer contents. Line buffers are never cleared.
- Arithmetic per center c with 8 neighbours n_i:
  - sum = Σn_i, width SIGNAL_bits+3.
  - avg = sum>>3.
  - m = max(c, avg).
  - `wr_signal` = m≥SIGNAL_DECAY ? m−SIGNAL_DECAY : 0. It never wraps.
- Read-before-write is guaranteed: cell (cx,cy) is written only after all its neighbours were read. Every output is therefore computed from pre-sweep values (Jacobi update).
- Write order is raster order of (cx,cy). Each cell is written exactly once per sweep: GRID_W×GRID_H writes.

## Timing
- Reset values: `busy`=0, `done`=0, `wr_flag`=0, `rd_x`=0, `rd_y`=0, `wr_x`=0, `wr_y`=0, `wr_signal`=0. FSM goes to IDLE and the scan counters go to 0.
- Pipeline, for `start` high at cycle 0:
  - Cycle 1: `busy`=1, scan position 0 = (0,0) issued on `rd_x`/`rd_y`.
  - Scan position p issues at cycle p+1; its data arrives at p+2.
  - The write for the center it completes is registered on the outputs at cycle p+3.
- With `wr_ready` held high:
  - Last position P=(GRID_W+1)(GRID_H+1)−1 writes at cycle P+3.
  - `done` pulses and `busy` falls at cycle P+4.
- Stall: while `wr_flag && !wr_ready`, every pipeline register, counter and `rd_*` output holds. Because `rd_x`/`rd_y` hold, `rd_signal` stays valid. There are no duplicated or dropped writes. Each stall cycle delays `done` by one cycle.
- `RESET_SIM` mid-sweep: back to IDLE next cycle with all outputs at reset values. A later `start` performs a complete, correct sweep.

## Structure
- Shared params package holds `X_bits`, `Y_bits`, `SIGNAL_bits`, `GRID_W`, `GRID_H`, `SIGNAL_DECAY`, and the FSM state enum `diff_state_t`.
- One sub-module: `signal_line_buffer`, a GRID_W×SIGNAL_bits shift RAM with read-then-write at the same index and a hold enable. Instantiate it twice.

## Test plan
Scenarios 2–6 override GRID_W=8, GRID_H=4, SIGNAL_DECAY=1. The bench models the environment as a registered-read array.
1. Reset asserted for 3 cycles → all outputs 0, `busy`=0. `start` during reset → no sweep.
2. All-zero grid, `start` at cycle 0, `wr_ready`=1 → 32 writes, all value 0, in raster order (0,0)..(7,3). Last write at cycle 47, `done` at cycle 48, `busy` high cycles 1–47.
3. Cell (3,2)=200, rest 0 →
   - (3,2) receives 199.
   - Its 8 neighbours receive 24 (200>>3=25, minus 1).
   - All other cells receive 0.
4. Corner (0,0)=255 and (7,3)=0 →
   - (0,0) receives 254.
   - (1,0), (0,1), (1,1) receive 30.
   - (7,3) receives 0 (saturating decay, no wrap).
5. Pseudo-random grid with `wr_ready` low for 5 cycles at the 10th write → outputs hold during the stall. Written values match the reference model, exactly 32 writes, `done` at cycle 53.
6. `RESET_SIM` at cycle 20 of a sweep, then `start` → full correct sweep. A second `start` while `busy` is ignored and produces only one `done`.

Source files
------------

// File: rtl/signal_diffuser_pkg.sv
// Shared constants and FSM state type for the pheromone diffusion sweep.
// Grid geometry defaults match a 640x480 playfield quantised to 4x4 cells.
package signal_diffuser_pkg;

   localparam int GRID_W       = 160;
   localparam int GRID_H       = 120;
   localparam int X_bits       = 8;
   localparam int Y_bits       = 7;
   localparam int SIGNAL_bits  = 8;
   localparam int SIGNAL_DECAY = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SWEEP,
      ST_DRAIN,
      ST_DONE
   } diff_state_t;

endpackage

// File: rtl/signal_diffuser_if.sv
// Control, lookup and write-back signals between the diffuser (master) and
// the environment / sim controller side (slave).
interface signal_diffuser_if
   import signal_diffuser_pkg::*;
#(
   parameter int XB = X_bits,
   parameter int YB = Y_bits,
   parameter int SB = SIGNAL_bits
);
   logic          start;
   logic          busy;
   logic          done;
   logic [XB-1:0] rd_x;
   logic [YB-1:0] rd_y;
   logic [SB-1:0] rd_signal;
   logic          wr_flag;
   logic          wr_ready;
   logic [XB-1:0] wr_x;
   logic [YB-1:0] wr_y;
   logic [SB-1:0] wr_signal;

   modport master (
      input  start, rd_signal, wr_ready,
      output busy, done, rd_x, rd_y, wr_flag, wr_x, wr_y, wr_signal
   );

   modport slave (
      output start, rd_signal, wr_ready,
      input  busy, done, rd_x, rd_y, wr_flag, wr_x, wr_y, wr_signal
   );
endinterface

// File: rtl/signal_diffuser_line_buffer.sv
// One grid row of signal values, indexed by column: combinational read of the
// old value and write of the new one at the same index, gated by en.
module signal_line_buffer
   import signal_diffuser_pkg::*;
#(
   parameter int DEPTH = GRID_W,
   parameter int WIDTH = SIGNAL_bits,
   parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             en,
   input  logic [AW-1:0]    idx,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data
);
   logic [WIDTH-1:0] mem [DEPTH];

   assign rd_data = mem[idx];

   always_ff @(posedge clk) begin
      if (en) mem[idx] <= wr_data;
   end
endmodule

// File: rtl/signal_diffuser.sv
// Between game ticks, raster-sweeps the pheromone grid and writes back each cell
// as max(center, neighbour average) minus a saturating decay (Jacobi update).
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | waiting for start; scan counters parked at (0,0)
//   ST_SWEEP | issuing one scan position per unstalled cycle
//   ST_DRAIN | all positions issued, waiting for the last write to leave
//   ST_DONE  | one-cycle done pulse, then back to idle
module signal_diffuser #(
   parameter int GRID_W       = signal_diffuser_pkg::GRID_W,
   parameter int GRID_H       = signal_diffuser_pkg::GRID_H,
   parameter int X_bits       = signal_diffuser_pkg::X_bits,
   parameter int Y_bits       = signal_diffuser_pkg::Y_bits,
   parameter int SIGNAL_bits  = signal_diffuser_pkg::SIGNAL_bits,
   parameter int SIGNAL_DECAY = signal_diffuser_pkg::SIGNAL_DECAY
) (
   input  logic              newLocClock,
   input  logic              RESET_SIM,
   signal_diffuser_if.master bus
);
   import signal_diffuser_pkg::*;

   localparam int SW    = SIGNAL_bits + 3;
   localparam int LB_AW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
   localparam logic [X_bits-1:0]      LAST_X = X_bits'(GRID_W);
   localparam logic [Y_bits-1:0]      LAST_Y = Y_bits'(GRID_H);
   localparam logic [SIGNAL_bits-1:0] DECAY  = SIGNAL_bits'(SIGNAL_DECAY);

   diff_state_t            state;
   logic [X_bits-1:0]      sx, s1_x, s2_x, rd_x_q, wr_x_q;
   logic [Y_bits-1:0]      sy, s1_y, s2_y, rd_y_q, wr_y_q;
   logic                   s1_v, s2_v, busy_q, done_q, wr_flag_q, stall_q;
   logic [SIGNAL_bits-1:0] wr_signal_q, rd_hold;
   logic [SIGNAL_bits-1:0] c0_t, c0_m, c0_b, c1_t, c1_m, c1_b;

   logic                   stall, issue, last_pos, pos_phantom;
   logic                   ph_col, ph_row, left_ok, wr_en, lb_en;
   logic [SIGNAL_bits-1:0] data_in, n_top, n_mid, n_bot, lb_a_rd, lb_b_rd;
   logic [SIGNAL_bits-1:0] avg, m, new_val;
   logic [SW-1:0]          sum;
   logic [LB_AW-1:0]       lb_idx;

   assign stall       = wr_flag_q && !bus.wr_ready;
   assign issue       = (state == ST_IDLE && bus.start) || (state == ST_SWEEP && !stall);
   assign last_pos    = (sx == LAST_X) && (sy == LAST_Y);
   assign pos_phantom = (sx == LAST_X) || (sy == LAST_Y);

   // While stalled, rd_signal follows the held rd_x (one position ahead), so
   // the word belonging to stage 2 is captured on the first stall cycle.
   assign data_in = stall_q ? rd_hold : bus.rd_signal;

   always_comb begin
      ph_col  = (s2_x == LAST_X);
      ph_row  = (s2_y == LAST_Y);
      left_ok = (s2_x >= X_bits'(2));
      n_bot   = (ph_col || ph_row) ? '0 : data_in;
      n_mid   = (!ph_col && s2_y != '0) ? lb_a_rd : '0;
      n_top   = (!ph_col && s2_y >= Y_bits'(2)) ? lb_b_rd : '0;
      sum     = SW'(c1_t) + SW'(c1_b) + SW'(n_top) + SW'(n_mid) + SW'(n_bot);
      if (left_ok) sum = sum + SW'(c0_t) + SW'(c0_m) + SW'(c0_b);
      avg     = SIGNAL_bits'(sum >> 3);
      m       = (c1_m > avg) ? c1_m : avg;
      new_val = (m >= DECAY) ? m - DECAY : '0;
      wr_en   = s2_v && (s2_x != '0) && (s2_y != '0);
      lb_en   = !stall && s2_v && !ph_col;
      lb_idx  = ph_col ? '0 : s2_x[LB_AW-1:0];
   end

   signal_line_buffer #(.DEPTH(GRID_W), .WIDTH(SIGNAL_bits), .AW(LB_AW)) u_lb_prev (
      .clk(newLocClock), .en(lb_en), .idx(lb_idx), .wr_data(n_bot), .rd_data(lb_a_rd)
   );

   signal_line_buffer #(.DEPTH(GRID_W), .WIDTH(SIGNAL_bits), .AW(LB_AW)) u_lb_prev2 (
      .clk(newLocClock), .en(lb_en), .idx(lb_idx), .wr_data(lb_a_rd), .rd_data(lb_b_rd)
   );

   always_ff @(posedge newLocClock) begin
      if (RESET_SIM) begin
         state       <= ST_IDLE;
         sx          <= '0;
         sy          <= '0;
         s1_v        <= 1'b0;
         s1_x        <= '0;
         s1_y        <= '0;
         s2_v        <= 1'b0;
         s2_x        <= '0;
         s2_y        <= '0;
         rd_x_q      <= '0;
         rd_y_q      <= '0;
         wr_x_q      <= '0;
         wr_y_q      <= '0;
         wr_signal_q <= '0;
         wr_flag_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         stall_q     <= 1'b0;
         rd_hold     <= '0;
         {c0_t, c0_m, c0_b, c1_t, c1_m, c1_b} <= '0;
      end else begin
         stall_q <= stall;
         if (!stall_q) rd_hold <= bus.rd_signal;

         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  state  <= ST_SWEEP;
                  busy_q <= 1'b1;
               end
            end
            ST_SWEEP: begin
               if (!stall && last_pos) state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (!stall && !s1_v && !s2_v) begin
                  state  <= ST_DONE;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            ST_DONE: begin
               state  <= ST_IDLE;
               done_q <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase

         if (!stall) begin
            s1_v <= issue;
            if (issue) begin
               s1_x <= sx;
               s1_y <= sy;
               if (!pos_phantom) begin
                  rd_x_q <= sx;
                  rd_y_q <= sy;
               end
               if (sx == LAST_X) begin
                  sx <= '0;
                  sy <= (sy == LAST_Y) ? '0 : sy + Y_bits'(1);
               end else begin
                  sx <= sx + X_bits'(1);
               end
            end

            s2_v <= s1_v;
            s2_x <= s1_x;
            s2_y <= s1_y;

            if (s2_v) begin
               {c0_t, c0_m, c0_b} <= {c1_t, c1_m, c1_b};
               {c1_t, c1_m, c1_b} <= {n_top, n_mid, n_bot};
            end

            wr_flag_q <= wr_en;
            if (wr_en) begin
               wr_x_q      <= s2_x - X_bits'(1);
               wr_y_q      <= s2_y - Y_bits'(1);
               wr_signal_q <= new_val;
            end
         end
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.rd_x      = rd_x_q;
   assign bus.rd_y      = rd_y_q;
   assign bus.wr_flag   = wr_flag_q;
   assign bus.wr_x      = wr_x_q;
   assign bus.wr_y      = wr_y_q;
   assign bus.wr_signal = wr_signal_q;
endmodule
